// File: rtl/frv_masked_bitwise_seq_pkg.sv
// -----------------------------------------------------------------------------
// frv_masked_pkg
// Shared definitions for the masked-ALU bitwise sequencer and its datapath:
//   - 2-bit operation encodings carried on req_op
//   - sequencer state enumeration
// -----------------------------------------------------------------------------
package frv_masked_pkg;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_IOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RND0 = 3'd1,
    ST_RND1 = 3'd2,
    ST_EXEC = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/frv_masked_bitwise_seq_dp.sv
// -----------------------------------------------------------------------------
// frv_masked_bitwise
// Two-share masked bitwise datapath. All four operation results are produced
// in parallel; the sequencer selects the pair it needs.
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_ena             : evaluation enable (one cycle per operation)
//   i_a0/i_a1/i_b0/i_b1 : operand shares
//   i_remask0/1       : fresh randomness (z0 refreshes AND cross terms,
//                       z1 remasks the XOR/AND outputs)
//   o_<op>0/o_<op>1   : result shares per operation
//   o_rdy             : high in the second half of the enable cycle
// -----------------------------------------------------------------------------
module frv_masked_bitwise #(
  parameter logic MASKING_ISE_DOM = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ena,
  input  logic [31:0] i_a0,
  input  logic [31:0] i_a1,
  input  logic [31:0] i_b0,
  input  logic [31:0] i_b1,
  input  logic [31:0] i_remask0,
  input  logic [31:0] i_remask1,
  output logic [31:0] o_xor0,
  output logic [31:0] o_xor1,
  output logic [31:0] o_and0,
  output logic [31:0] o_and1,
  output logic [31:0] o_ior0,
  output logic [31:0] o_ior1,
  output logic [31:0] o_not0,
  output logic [31:0] o_not1,
  output logic        o_rdy
);

  logic r_half;

  // Marks the second half of the enable cycle.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_half <= 1'b0;
    end else begin
      r_half <= i_ena;
    end
  end

  assign o_rdy  = i_ena & r_half;

  // XOR is share-wise; the same word on both shares keeps the sum intact.
  assign o_xor0 = i_a0 ^ i_b0 ^ i_remask1;
  assign o_xor1 = i_a1 ^ i_b1 ^ i_remask1;

  // NOT only needs one share inverted.
  assign o_not0 = ~i_a0;
  assign o_not1 = i_a1;

  generate
    if (MASKING_ISE_DOM) begin : g_dom
      logic [31:0] r_cross0;
      logic [31:0] r_cross1;

      // Refreshed cross-domain terms, registered mid-cycle so the two shares
      // never combine in one cone; cleared again outside the enable cycle.
      always_ff @(negedge i_clk) begin
        if (i_reset) begin
          r_cross0 <= 32'h0000_0000;
          r_cross1 <= 32'h0000_0000;
        end else if (i_ena) begin
          r_cross0 <= (i_a0 & i_b1) ^ i_remask0;
          r_cross1 <= (i_a1 & i_b0) ^ i_remask0;
        end else begin
          r_cross0 <= 32'h0000_0000;
          r_cross1 <= 32'h0000_0000;
        end
      end

      assign o_and0 = (i_a0 & i_b0) ^ r_cross0 ^ i_remask1;
      assign o_and1 = (i_a1 & i_b1) ^ r_cross1 ^ i_remask1;
    end else begin : g_naive
      // Unmasks before the AND; only for comparison builds.
      assign o_and0 = ((i_a0 ^ i_a1) & (i_b0 ^ i_b1)) ^ i_remask0;
      assign o_and1 = i_remask0;
    end
  endgenerate

  // Operands arrive as (a0, ~a1), (b0, ~b1), so the AND pair holds ~(a|b);
  // inverting one share yields a|b.
  assign o_ior0 = ~o_and0;
  assign o_ior1 = o_and1;

endmodule

// File: rtl/frv_masked_bitwise_seq.sv
// -----------------------------------------------------------------------------
// frv_masked_bitwise_seq
// Sequences one masked bitwise operation: accepts a request, fetches the
// randomness it needs, runs the datapath for one enable cycle and returns the
// two result shares. Operand, randomness and result registers are zeroised
// after use or on abort.
//   g_clk, g_reset          : clock, synchronous active-high reset
//   flush                   : synchronous abort of the operation in flight
//   req_valid/req_ready     : request handshake (req_op, req_a0/a1/b0/b1)
//   rng_valid/rng_ready     : randomness handshake (rng_data)
//   rsp_valid/rsp_ready     : response handshake (rsp_r0, rsp_r1)
//   busy                    : high whenever not idle
// -----------------------------------------------------------------------------
module frv_masked_bitwise_seq
  import frv_masked_pkg::*;
#(
  parameter logic MASKING_ISE_DOM = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic        rng_valid,
  output logic        rng_ready,
  input  logic [31:0] rng_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_r0,
  output logic [31:0] rsp_r1,
  output logic        busy
);

  state_t      r_state;
  logic        r_idle;
  logic        r_rng_ready;
  logic        r_rsp_valid;
  logic        r_busy;
  logic [1:0]  r_op;
  logic [31:0] r_a0, r_a1, r_b0, r_b1;
  logic [31:0] r_z0, r_z1;
  logic [31:0] r_rsp_r0, r_rsp_r1;

  logic        w_ena;
  logic [31:0] w_xor0, w_xor1, w_and0, w_and1;
  logic [31:0] w_ior0, w_ior1, w_not0, w_not1;
  logic [31:0] w_res0, w_res1;
  logic        w_dp_rdy_unused;

  assign w_ena     = (r_state == ST_EXEC);
  assign req_ready = r_idle & ~flush;
  assign rng_ready = r_rng_ready;
  assign rsp_valid = r_rsp_valid;
  assign busy      = r_busy;
  assign rsp_r0    = r_rsp_r0;
  assign rsp_r1    = r_rsp_r1;

  frv_masked_bitwise #(
    .MASKING_ISE_DOM (MASKING_ISE_DOM)
  ) u_dp (
    .i_clk     (g_clk),
    .i_reset   (g_reset),
    .i_ena     (w_ena),
    .i_a0      (r_a0),
    .i_a1      (r_a1),
    .i_b0      (r_b0),
    .i_b1      (r_b1),
    .i_remask0 (r_z0),
    .i_remask1 (r_z1),
    .o_xor0    (w_xor0),
    .o_xor1    (w_xor1),
    .o_and0    (w_and0),
    .o_and1    (w_and1),
    .o_ior0    (w_ior0),
    .o_ior1    (w_ior1),
    .o_not0    (w_not0),
    .o_not1    (w_not1),
    .o_rdy     (w_dp_rdy_unused)
  );

  // Select the result pair belonging to the latched operation.
  always_comb begin
    w_res0 = w_not0;
    w_res1 = w_not1;
    case (r_op)
      OP_XOR:  begin w_res0 = w_xor0; w_res1 = w_xor1; end
      OP_AND:  begin w_res0 = w_and0; w_res1 = w_and1; end
      OP_IOR:  begin w_res0 = w_ior0; w_res1 = w_ior1; end
      default: begin w_res0 = w_not0; w_res1 = w_not1; end
    endcase
  end

  // Sequencer FSM with all data registers and registered handshake outputs.
  always_ff @(posedge g_clk) begin
    if (g_reset || flush) begin
      r_state     <= ST_IDLE;
      r_idle      <= 1'b1;
      r_rng_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_op        <= OP_XOR;
      r_a0        <= 32'h0000_0000;
      r_a1        <= 32'h0000_0000;
      r_b0        <= 32'h0000_0000;
      r_b1        <= 32'h0000_0000;
      r_z0        <= 32'h0000_0000;
      r_z1        <= 32'h0000_0000;
      r_rsp_r0    <= 32'h0000_0000;
      r_rsp_r1    <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_op   <= req_op;
            r_a0   <= req_a0;
            r_b0   <= req_b0;
            r_idle <= 1'b0;
            r_busy <= 1'b1;
            // IOR is computed as an AND on complemented operands.
            if (req_op == OP_IOR) begin
              r_a1 <= ~req_a1;
              r_b1 <= ~req_b1;
            end else begin
              r_a1 <= req_a1;
              r_b1 <= req_b1;
            end
            case (req_op)
              OP_XOR: begin
                r_state     <= ST_RND1;
                r_rng_ready <= 1'b1;
              end
              OP_NOT: begin
                r_state     <= ST_EXEC;
                r_rng_ready <= 1'b0;
              end
              default: begin
                r_state     <= ST_RND0;
                r_rng_ready <= 1'b1;
              end
            endcase
          end
        end
        ST_RND0: begin
          if (rng_valid) begin
            r_z0    <= rng_data;
            r_state <= ST_RND1;
          end
        end
        ST_RND1: begin
          if (rng_valid) begin
            r_z1        <= rng_data;
            r_state     <= ST_EXEC;
            r_rng_ready <= 1'b0;
          end
        end
        ST_EXEC: begin
          r_rsp_r0    <= w_res0;
          r_rsp_r1    <= w_res1;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_idle      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= OP_XOR;
            r_a0        <= 32'h0000_0000;
            r_a1        <= 32'h0000_0000;
            r_b0        <= 32'h0000_0000;
            r_b1        <= 32'h0000_0000;
            r_z0        <= 32'h0000_0000;
            r_z1        <= 32'h0000_0000;
            r_rsp_r0    <= 32'h0000_0000;
            r_rsp_r1    <= 32'h0000_0000;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idle      <= 1'b1;
          r_rng_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frv_masked_bitwise_seq.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for frv_masked_bitwise_seq. Two instances (DOM and naive
// AND) share all inputs; the expected unmasked result, latency and number of
// randomness handshakes are pushed per request and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_frv_masked_bitwise_seq;

  logic        g_clk = 1'b0;
  logic        g_reset, flush, req_valid, rng_valid, rsp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, rng_data;
  logic        req_ready, rng_ready, rsp_valid, busy;
  logic [31:0] rsp_r0, rsp_r1;
  logic        req_ready_n, rng_ready_n, rsp_valid_n, busy_n;
  logic [31:0] rsp_r0_n, rsp_r1_n;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          rng;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   allow_orphan = 1'b0;

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  frv_masked_bitwise_seq #(.MASKING_ISE_DOM(1'b1)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_data(rng_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r0(rsp_r0), .rsp_r1(rsp_r1), .busy(busy)
  );

  frv_masked_bitwise_seq #(.MASKING_ISE_DOM(1'b0)) dut_n (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready_n), .req_op(req_op),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rng_valid(rng_valid), .rng_ready(rng_ready_n), .rng_data(rng_data),
    .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready),
    .rsp_r0(rsp_r0_n), .rsp_r1(rsp_r1_n), .busy(busy_n)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Observes all handshakes at the negedge and scores responses.
  task automatic monitor();
    int          acc_cyc = 0;
    int          rng_cnt = 0;
    bit          prev_stall = 1'b0;
    bit          prev_v = 1'b0;
    logic [31:0] h0 = 32'h0, h1 = 32'h0;
    exp_t        e;
    forever begin
      @(negedge g_clk);
      if (g_reset) begin
        prev_stall = 1'b0;
        prev_v     = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          acc_cyc = cyc;
          rng_cnt = 0;
        end
        if (rng_valid && rng_ready) rng_cnt++;
        chk("twin_rsp_valid", 32'(rsp_valid_n), 32'(rsp_valid));
        chk("twin_busy", 32'(busy_n), 32'(busy));
        if (rsp_valid && !prev_v) begin
          if (sb_q.size() == 0) begin
            if (!allow_orphan) chk("orphan_rsp", 32'(rsp_valid), 32'h0);
          end else begin
            chk("latency", 32'(cyc - acc_cyc), 32'(sb_q[0].lat));
          end
        end
        if (rsp_valid && prev_stall) begin
          chk("hold_r0", rsp_r0, h0);
          chk("hold_r1", rsp_r1, h1);
        end
        if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("result_dom", rsp_r0 ^ rsp_r1, e.res);
          chk("result_naive", rsp_r0_n ^ rsp_r1_n, e.res);
          chk("rng_handshakes", 32'(rng_cnt), 32'(e.rng));
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_v     = rsp_valid;
        h0         = rsp_r0;
        h1         = rsp_r1;
      end
    end
  endtask

  // Issue one request; expected behaviour comes from the operation rules.
  task automatic issue(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] b0, input logic [31:0] b1,
                       input int rng_stall, input int rsp_stall);
    exp_t        e;
    logic [31:0] a, b;
    int          guard;
    a = a0 ^ a1;
    b = b0 ^ b1;
    case (op)
      2'b00:   begin e.res = a ^ b; e.rng = 1; e.lat = 3; end
      2'b01:   begin e.res = a & b; e.rng = 2; e.lat = 4; end
      2'b10:   begin e.res = a | b; e.rng = 2; e.lat = 4; end
      default: begin e.res = ~a;    e.rng = 0; e.lat = 2; end
    endcase
    if (e.rng > 0) e.lat = e.lat + rng_stall;
    @(posedge g_clk); #1;
    req_op = op; req_a0 = a0; req_a1 = a1; req_b0 = b0; req_b1 = b1;
    req_valid = 1'b1;
    rsp_ready = (rsp_stall == 0);
    guard = 0;
    @(negedge g_clk);
    while (!req_ready && guard < 50) begin
      @(negedge g_clk);
      guard++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'h1);
    sb_q.push_back(e);
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    if (rng_stall > 0) begin
      rng_valid = 1'b0;
      repeat (rng_stall) @(posedge g_clk);
      #1 rng_valid = 1'b1;
    end
    if (rsp_stall > 0) begin
      guard = 0;
      while (!rsp_valid && guard < 50) begin
        @(negedge g_clk);
        guard++;
      end
      repeat (rsp_stall) @(posedge g_clk);
      #1 rsp_ready = 1'b1;
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge g_clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      chk("rsp_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1);
    @(posedge g_clk); #1;
    req_op = op; req_a0 = a0; req_a1 = a1; req_b0 = $urandom; req_b1 = $urandom;
    req_valid = 1'b1;
    @(negedge g_clk);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    @(posedge g_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_rsp_r0"}, rsp_r0, 32'h0);
    chk({tag, "_rsp_r1"}, rsp_r1, 32'h0);
    chk({tag, "_z0"}, dut.r_z0, 32'h0);
    chk({tag, "_z1"}, dut.r_z1, 32'h0);
    chk({tag, "_a0"}, dut.r_a0, 32'h0);
    chk({tag, "_a1"}, dut.r_a1, 32'h0);
    chk({tag, "_b0"}, dut.r_b0, 32'h0);
    chk({tag, "_b1"}, dut.r_b1, 32'h0);
  endtask

  initial begin
    logic [31:0] s0, s1, t0, t1;
    logic [1:0]  rop;
    g_reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rng_valid = 1'b1; rsp_ready = 1'b1;
    req_op = 2'b00; req_a0 = 32'h0; req_a1 = 32'h0; req_b0 = 32'h0; req_b1 = 32'h0;
    rng_data = 32'h0;
    fork
      monitor();
      forever begin
        @(posedge g_clk); #1 rng_data = $urandom;
      end
      begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rng_ready", 32'(rng_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_r0", rsp_r0, 32'h0);
    chk("rst_rsp_r1", rsp_r1, 32'h0);
    @(posedge g_clk); #1 g_reset = 1'b0;

    // Fixed operands from the plan.
    issue(2'b00, 32'h12345678, 32'h1D3B5977, 32'hAAAAAAAA, 32'h55AA55AA, 0, 0);
    for (int i = 0; i < 200; i++)
      issue(2'b01, 32'h12345678, 32'h1D3B5977, 32'hAAAAAAAA, 32'h55AA55AA, 0, 0);
    issue(2'b10, 32'h12345678, 32'h1D3B5977, 32'hAAAAAAAA, 32'h55AA55AA, 0, 0);
    s0 = $urandom;
    issue(2'b11, s0, s0 ^ 32'h0000FFFF, $urandom, $urandom, 0, 0);

    // Stalls on randomness and on the response.
    issue(2'b01, 32'h12345678, 32'h1D3B5977, 32'hAAAAAAAA, 32'h55AA55AA, 5, 3);
    @(negedge g_clk);
    chk_idle("post_rsp");

    // Random operations, shares and occasional stalls.
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      s0 = $urandom; s1 = $urandom; t0 = $urandom; t1 = $urandom;
      issue(rop, s0, s1, t0, t1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Flush in RND1.
    start_req(2'b01, $urandom, $urandom);
    @(posedge g_clk); #1 flush = 1'b1;
    @(negedge g_clk);
    chk("flush_rnd1_busy_pre", 32'(busy), 32'h1);
    chk("flush_rnd1_ready_low", 32'(req_ready), 32'h0);
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    chk_idle("flush_rnd1");
    repeat (5) @(negedge g_clk);
    chk("flush_rnd1_no_rsp", 32'(rsp_valid), 32'h0);

    // Flush in EXEC.
    start_req(2'b11, $urandom, $urandom);
    flush = 1'b1;
    @(negedge g_clk);
    chk("flush_exec_busy_pre", 32'(busy), 32'h1);
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    chk_idle("flush_exec");
    repeat (5) @(negedge g_clk);
    chk("flush_exec_no_rsp", 32'(rsp_valid), 32'h0);

    // Reset while a response is pending.
    allow_orphan = 1'b1;
    rsp_ready = 1'b0;
    s0 = $urandom;
    start_req(2'b11, s0, s0 ^ 32'h00FF00FF);
    @(negedge g_clk);
    @(negedge g_clk);
    chk("rst_rsp_pending", 32'(rsp_valid), 32'h1);
    chk("rst_rsp_value", rsp_r0 ^ rsp_r1, 32'hFF00FF00);
    @(posedge g_clk); #1 g_reset = 1'b1;
    @(posedge g_clk); #1 g_reset = 1'b0;
    @(negedge g_clk);
    chk_idle("reset_rsp");
    allow_orphan = 1'b0;
    rsp_ready = 1'b1;

    // Recovery after the aborts.
    issue(2'b10, 32'h12345678, 32'h1D3B5977, 32'hAAAAAAAA, 32'h55AA55AA, 0, 0);
    issue(2'b00, $urandom, $urandom, $urandom, $urandom, 2, 0);

    repeat (3) @(negedge g_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
